// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I decode into ALU src1/src2/func plus branch/jump target, held in a one-entry valid/ready slot
module alu_op_decoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [3:0]  func_o,
  output logic [31:0] target_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);
  localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b0001, F_XOR = 4'b0010, F_OR = 4'b0011,
                         F_AND = 4'b0100, F_SLTU = 4'b0101, F_SLT = 4'b0110, F_SLL = 4'b0111,
                         F_SRL = 4'b1000, F_SRA = 4'b1001, F_EQ = 4'b1010, F_NE = 4'b1011,
                         F_GEU = 4'b1100, F_GE = 4'b1101, F_PC4 = 4'b1110, F_PASS = 4'b1111;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        shift, alt_ok;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;
  logic [31:0] src1_d, src2_d, target_d;
  logic [3:0]  func_d;
  logic [4:0]  rd_d;
  logic        illegal_d, valid_d, load;
  logic [31:0] src1_q, src2_q, target_q, pc_q;
  logic [3:0]  func_q;
  logic [4:0]  rd_q;
  logic        illegal_q, valid_q;
  assign opc    = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign shift  = f3[1:0] == 2'b01;
  // funct7 may only be all-zero, or 0100000 for the SUB/SRA slot (funct3 000 for OP, 101 for both)
  assign alt_ok = f7 == 7'b0000000 || (f7 == 7'b0100000 && f3[1:0] == 2'b01 ? f3[2] : f7 == 7'b0100000 && f3 == 3'b000);
  assign i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm  = {instr_i[31:12], 12'b0};
  assign j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign sh_imm = {27'b0, instr_i[24:20]};
  function automatic logic [3:0] alu_f(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  return alt ? F_SUB : F_ADD;
      3'b001:  return F_SLL;
      3'b010:  return F_SLT;
      3'b011:  return F_SLTU;
      3'b100:  return F_XOR;
      3'b101:  return alt ? F_SRA : F_SRL;
      3'b110:  return F_OR;
      default: return F_AND;
    endcase
  endfunction
  function automatic logic [3:0] br_f(input logic [2:0] f);
    case (f)
      3'b000:  return F_EQ;
      3'b001:  return F_NE;
      3'b100:  return F_SLT;
      3'b101:  return F_GE;
      3'b110:  return F_SLTU;
      3'b111:  return F_GEU;
      default: return F_PASS;
    endcase
  endfunction
  always_comb begin
    src1_d    = '0;
    src2_d    = '0;
    target_d  = '0;
    func_d    = F_PASS;
    rd_d      = '0;
    illegal_d = 1'b0;
    case (opc)
      7'b0110011: begin
        src1_d    = rs1_data_i;
        src2_d    = rs2_data_i;
        func_d    = alu_f(f3, f7[5]);
        rd_d      = rd;
        illegal_d = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0010011: begin
        src1_d    = rs1_data_i;
        src2_d    = shift ? sh_imm : i_imm;
        func_d    = alu_f(f3, shift & f7[5]);
        rd_d      = rd;
        illegal_d = shift && !alt_ok;
      end
      7'b0000011: begin
        src1_d = rs1_data_i;
        src2_d = i_imm;
        func_d = F_ADD;
        rd_d   = rd;
      end
      7'b0100011: begin
        src1_d = rs1_data_i;
        src2_d = s_imm;
        func_d = F_ADD;
      end
      7'b0110111: begin
        src2_d = u_imm;
        rd_d   = rd;
      end
      7'b0010111: begin
        src1_d = pc_i;
        src2_d = u_imm;
        func_d = F_ADD;
        rd_d   = rd;
      end
      7'b1101111: begin
        src1_d   = pc_i;
        func_d   = F_PC4;
        target_d = pc_i + j_imm;
        rd_d     = rd;
      end
      7'b1100111: begin
        src1_d   = pc_i;
        func_d   = F_PC4;
        target_d = (rs1_data_i + i_imm) & ~32'd1;
        rd_d     = rd;
      end
      7'b1100011: begin
        src1_d    = rs1_data_i;
        src2_d    = rs2_data_i;
        func_d    = br_f(f3);
        target_d  = pc_i + b_imm;
        illegal_d = f3[2:1] == 2'b01;
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      src1_d   = '0;
      src2_d   = '0;
      target_d = '0;
      func_d   = F_PASS;
      rd_d     = '0;
    end
  end
  always_comb begin
    in_ready_o = !valid_q | out_ready_i;
    load       = in_valid_i & in_ready_o & !flush_i;
    valid_d    = flush_i ? 1'b0 : load ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      func_q    <= F_ADD;
      target_q  <= '0;
      pc_q      <= RESET_PC;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        src1_q    <= src1_d;
        src2_q    <= src2_d;
        func_q    <= func_d;
        target_q  <= target_d;
        pc_q      <= pc_i;
        rd_q      <= rd_d;
        illegal_q <= illegal_d;
      end
    end
  end
  assign out_valid_o = valid_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign func_o      = func_q;
  assign target_o    = target_q;
  assign pc_o        = pc_q;
  assign rd_o        = rd_q;
  assign illegal_o   = illegal_q;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed RV32I vectors with a scoreboard queue checked by an output monitor
module tb_alu_op_decoder;
  localparam logic [31:0] RPC = 32'hDEAD_BEE0;
  logic        clk = 1'b0, reset, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, illegal_o;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i, src1_o, src2_o, target_o, pc_o;
  logic [3:0]  func_o;
  logic [4:0]  rd_o;
  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  func;
    logic [31:0] target;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;
  exp_t exp_in;
  exp_t sb[$];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  alu_op_decoder #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .src1_o(src1_o), .src2_o(src2_o),
    .func_o(func_o), .target_o(target_o), .pc_o(pc_o), .rd_o(rd_o), .illegal_o(illegal_o)
  );
  function automatic exp_t mk(input logic [31:0] s1, s2, input logic [3:0] f,
                              input logic [31:0] t, p, input logic [4:0] r, input logic il);
    return '{s1, s2, f, t, p, r, il};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask
  // Monitor first, then record any op that the upcoming edge will accept
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got op at pc %h want none", pc_o);
      end else begin
        exp_t e, got;
        e   = sb.pop_front();
        got = {src1_o, src2_o, func_o, target_o, pc_o, rd_o, illegal_o};
        checks++;
        if (got === e) passed++;
        else $display("FAIL op_pc_%h: got src1=%h src2=%h func=%h tgt=%h pc=%h rd=%0d ill=%b want src1=%h src2=%h func=%h tgt=%h pc=%h rd=%0d ill=%b",
                      e.pc, got.src1, got.src2, got.func, got.target, got.pc, got.rd, got.ill,
                      e.src1, e.src2, e.func, e.target, e.pc, e.rd, e.ill);
      end
    end
    if (in_valid_i && in_ready_o && !flush_i && !reset) sb.push_back(exp_in);
  end
  task automatic drive(input logic [31:0] ins, pc, r1, r2, input exp_t e);
    logic acc;
    instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2; exp_in = e; in_valid_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = in_ready_o && !flush_i;
      @(posedge clk);
      #1;
      if (acc) break;
      if (n == 19) begin
        checks++;
        $display("FAIL accept_timeout: got no accept for pc %h want accept within 20 cycles", pc);
      end
    end
    in_valid_i = 1'b0;
  endtask
  initial begin
    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_func", func_o, 0);
    chk("rst_pc", pc_o, RPC);
    chk("rst_src", {src1_o, src2_o, target_o}, 0);
    chk("rst_rd_ill", {rd_o, illegal_o}, 0);
    chk("rst_ready", in_ready_o, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'h1, 32'h0, 32'h0, 5'd3, 1'b0));
    drive(32'hFE20ECE3, 32'h100, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'h5, 32'hF8, 32'h100, 5'd0, 1'b0));
    drive(32'h004082E7, 32'h40, 32'h1001, 32'd0, mk(32'h40, 32'h0, 4'hE, 32'h1004, 32'h40, 5'd5, 1'b0));
    drive(32'hFFF10393, 32'h44, 32'd5, 32'd99, mk(32'd5, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h44, 5'd7, 1'b0));
    drive(32'h4030D093, 32'h48, 32'h80000000, 32'd0, mk(32'h80000000, 32'd3, 4'h9, 32'h0, 32'h48, 5'd1, 1'b0));
    drive(32'h40109093, 32'h4C, 32'd7, 32'd7, mk(32'h0, 32'h0, 4'hF, 32'h0, 32'h4C, 5'd0, 1'b1));
    drive(32'h12345537, 32'h50, 32'd1, 32'd2, mk(32'h0, 32'h12345000, 4'hF, 32'h0, 32'h50, 5'd10, 1'b0));
    drive(32'hFFFFF217, 32'h10, 32'd1, 32'd2, mk(32'h10, 32'hFFFFF000, 4'h0, 32'h0, 32'h10, 5'd4, 1'b0));
    drive(32'hFFDFF0EF, 32'h200, 32'd1, 32'd2, mk(32'h200, 32'h0, 4'hE, 32'h1FC, 32'h200, 5'd1, 1'b0));
    drive(32'h0021A423, 32'h60, 32'h1000, 32'd55, mk(32'h1000, 32'd8, 4'h0, 32'h0, 32'h60, 5'd0, 1'b0));
    drive(32'h00000863, 32'hFFFFFFF0, 32'd4, 32'd4, mk(32'd4, 32'd4, 4'hA, 32'h0, 32'hFFFFFFF0, 5'd0, 1'b0));
    drive(32'h0020F333, 32'h64, 32'hF0F0, 32'h0FF0, mk(32'hF0F0, 32'h0FF0, 4'h4, 32'h0, 32'h64, 5'd6, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    drive(32'hFFF10393, 32'h80, 32'd9, 32'd0, mk(32'd9, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h80, 5'd7, 1'b0));
    instr_i = 32'h402081B3; pc_i = 32'h84; rs1_data_i = 32'd20; rs2_data_i = 32'd1;
    exp_in = mk(32'd20, 32'd1, 4'h1, 32'h0, 32'h84, 5'd3, 1'b0);
    in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", in_ready_o, 0);
      chk("stall_valid", out_valid_o, 1);
      chk("stall_frozen", {src1_o, src2_o, func_o, pc_o, rd_o}, {32'd9, 32'hFFFFFFFF, 4'h0, 32'h80, 5'd7});
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("stall_release_valid", out_valid_o, 1);
    chk("stall_release_pc", pc_o, 32'h84);
    @(posedge clk);
    #1;
    flush_i = 1'b1; instr_i = 32'h0; pc_i = 32'h300; rs1_data_i = 32'd1; rs2_data_i = 32'd2;
    exp_in = mk(32'h0, 32'h0, 4'hF, 32'h0, 32'h300, 5'd0, 1'b1);
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid", out_valid_o, 0);
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("post_flush_illegal", {out_valid_o, illegal_o, func_o}, {1'b1, 1'b1, 4'hF});
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    drive(32'h12345537, 32'h400, 32'd0, 32'd0, mk(32'h0, 32'h12345000, 4'hF, 32'h0, 32'h400, 5'd10, 1'b0));
    @(negedge clk);
    chk("pre_reset_valid", out_valid_o, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_func", func_o, 0);
    chk("async_rst_pc", pc_o, RPC);
    chk("async_rst_data", {src2_o, rd_o}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
